// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_MUL = 4'd8,
    ALU_DIV = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } alu_state_e;

endpackage

// File: rtl/alu_iter_engine.sv
// Multi-cycle datapath: shift-add multiplier, plus a restoring divider when
// ALU_DIV_EN is defined. One step per cycle; 'last' flags the final step.
module alu_iter_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_d, lo_d;

  // Multiplier: hi:lo holds partial product over the shifting multiplier.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_addend = lo_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
  assign mul_hi     = mul_sum[WIDTH:1];
  assign mul_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // Divider: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic             is_div_q;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;

  assign div_sh = {hi_q, lo_q[WIDTH-1]};
  assign div_ge = (div_sh >= {1'b0, opnd_q});
  assign div_hi = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
  assign div_lo = {lo_q[WIDTH-2:0], div_ge};
`endif

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    hi_d  = mul_hi;
    lo_d  = mul_lo;
    carry = |mul_hi;
`ifdef ALU_DIV_EN
    if (is_div_q) begin
      hi_d  = div_hi;
      lo_d  = div_lo;
      carry = 1'b0;
    end
`endif
  end

  // The value after this cycle's step; sampled by the caller on the last step.
  assign res  = lo_d;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: datapath registers carry no reset; every load fully reinitialises them.
  always_ff @(posedge clk) begin
    if (load) begin
      hi_q <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= is_div;
      lo_q     <= is_div ? a : b;
      opnd_q   <= is_div ? b : a;
`else
      lo_q   <= b;
      opnd_q <= a;
`endif
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage feeding the flag register. Single-cycle ops finish in
// DONE directly; MUL (and DIV under ALU_DIV_EN) iterate WIDTH cycles in ITER.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                alu_rst,
  input  logic                alu_start,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_a,
  input  logic [WIDTH-1:0]    alu_b,
  output logic                alu_ready,
  output logic                alu_done,
  output logic [WIDTH-1:0]    alu_result,
  output logic                alu_c,
  output logic                alu_z,
  output logic                alu_b_flag,
  output logic                alu_cb_valid
);

  alu_state_e state_q, state_d;
  alu_op_e    op;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_bf, sc_cb, go_iter;
  logic             sc_load, it_load, eng_load, eng_step;

  logic [WIDTH-1:0] result_q;
  logic             c_q, z_q, bf_q, cb_q;

  logic             eng_last, eng_c;
  logic [WIDTH-1:0] eng_res;

  assign op      = alu_op_e'(alu_op);
  assign add_sum = {1'b0, alu_a} + {1'b0, alu_b};

  // Single-cycle decode straight from the request inputs.
  always_comb begin
    sc_res  = alu_a;
    sc_c    = 1'b0;
    sc_bf   = 1'b0;
    sc_cb   = 1'b0;
    go_iter = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_cb  = 1'b1;
      end
      ALU_SUB: begin
        sc_res = alu_a - alu_b;
        sc_bf  = (alu_a < alu_b);
        sc_cb  = 1'b1;
      end
      ALU_AND: sc_res = alu_a & alu_b;
      ALU_OR:  sc_res = alu_a | alu_b;
      ALU_XOR: sc_res = alu_a ^ alu_b;
      ALU_NOT: sc_res = ~alu_a;
      ALU_SHL: begin
        sc_res = {alu_a[WIDTH-2:0], 1'b0};
        sc_c   = alu_a[WIDTH-1];
        sc_cb  = 1'b1;
      end
      ALU_SHR: begin
        sc_res = {1'b0, alu_a[WIDTH-1:1]};
        sc_c   = alu_a[0];
        sc_cb  = 1'b1;
      end
      ALU_MUL: go_iter = 1'b1;
`ifdef ALU_DIV_EN
      ALU_DIV: begin
        // Divide-by-zero short-circuits to an all-ones quotient with borrow set.
        if (alu_b == '0) begin
          sc_res = '1;
          sc_bf  = 1'b1;
          sc_cb  = 1'b1;
        end else begin
          go_iter = 1'b1;
        end
      end
`endif
      default: sc_res = alu_a;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sc_load  = 1'b0;
    it_load  = 1'b0;
    eng_load = 1'b0;
    eng_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_start) begin
          if (go_iter) begin
            eng_load = 1'b1;
            state_d  = ITER;
          end else begin
            sc_load  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      ITER: begin
        eng_step = 1'b1;
        if (eng_last) begin
          it_load = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags load only on the edge entering DONE and hold until the next completion.
  always_ff @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      bf_q     <= 1'b0;
      cb_q     <= 1'b0;
    end else if (sc_load) begin
      result_q <= sc_res;
      z_q      <= (sc_res == '0);
      cb_q     <= sc_cb;
      if (sc_cb) begin
        c_q  <= sc_c;
        bf_q <= sc_bf;
      end
    end else if (it_load) begin
      result_q <= eng_res;
      z_q      <= (eng_res == '0);
      cb_q     <= 1'b1;
      c_q      <= eng_c;
      bf_q     <= 1'b0;
    end
  end

  alu_iter_engine #(
    .WIDTH(WIDTH)
  ) u_engine (
    .clk   (clk),
    .rst   (alu_rst),
    .load  (eng_load),
    .step  (eng_step),
`ifdef ALU_DIV_EN
    .is_div(op == ALU_DIV),
`endif
    .a     (alu_a),
    .b     (alu_b),
    .last  (eng_last),
    .res   (eng_res),
    .carry (eng_c)
  );

  assign alu_ready    = (state_q == IDLE);
  assign alu_done     = (state_q == DONE);
  assign alu_cb_valid = alu_done & cb_q;
  assign alu_result   = result_q;
  assign alu_c        = c_q;
  assign alu_z        = z_q;
  assign alu_b_flag   = bf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus random ops
// checked against an arithmetic reference model. Honours ALU_DIV_EN.
module tb_alu_seq;

  localparam int          W    = 8;
  localparam logic [31:0] MASK = (32'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         alu_rst, alu_start;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_ready, alu_done, alu_c, alu_z, alu_b_flag, alu_cb_valid;
  logic [W-1:0] alu_result;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_c, m_bf;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .alu_rst     (alu_rst),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ready   (alu_ready),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_b_flag  (alu_b_flag),
    .alu_cb_valid(alu_cb_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ready"},  alu_ready,    1);
    check({tag, " done"},   alu_done,     0);
    check({tag, " result"}, alu_result,   0);
    check({tag, " c"},      alu_c,        0);
    check({tag, " z"},      alu_z,        0);
    check({tag, " bflag"},  alu_b_flag,   0);
    check({tag, " cbv"},    alu_cb_valid, 0);
  endtask

  // Reference model: expected result, latency and cb_valid; updates held c/borrow.
  task automatic model(input int op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output logic cb);
    longint p;
    r   = a;
    cb  = 1'b0;
    lat = 1;
    case (op)
      0: begin p = longint'(a) + longint'(b); r = 32'(p) & MASK;
               m_c = (p >> W) != 0; m_bf = 0; cb = 1; end
      1: begin r = (a - b) & MASK; m_c = 0; m_bf = (a < b); cb = 1; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a & MASK;
      6: begin r = (a << 1) & MASK; m_c = (a >> (W - 1)) & 1; m_bf = 0; cb = 1; end
      7: begin r = a >> 1; m_c = a[0]; m_bf = 0; cb = 1; end
      8: begin p = longint'(a) * longint'(b); r = 32'(p) & MASK;
               m_c = (p >> W) != 0; m_bf = 0; cb = 1; lat = W + 1; end
`ifdef ALU_DIV_EN
      9: begin
        cb = 1; m_c = 0;
        if (b == 0) begin r = MASK; m_bf = 1; end
        else begin r = a / b; m_bf = 0; lat = W + 1; end
      end
`endif
      default: r = a;
    endcase
  endtask

  task automatic run_op(input string tag, input int op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    logic [31:0] er;
    int          elat, lat;
    logic        ecb, seen;
    check({tag, " ready"}, alu_ready, 1);
    model(op, 32'(a), 32'(b), er, elat, ecb);
    alu_op    = op[3:0];
    alu_a     = a;
    alu_b     = b;
    alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (alu_done) begin
        lat = k;
        break;
      end
      alu_start = (poke && k < W) ? k[0] : 1'b0;
      tick();
    end
    alu_start = 1'b0;
    check({tag, " latency"}, lat,          elat);
    check({tag, " result"},  alu_result,   er);
    check({tag, " c"},       alu_c,        m_c);
    check({tag, " z"},       alu_z,        (er == 0));
    check({tag, " bflag"},   alu_b_flag,   m_bf);
    check({tag, " cbv"},     alu_cb_valid, ecb);
    tick();
    check({tag, " done1"},  alu_done,  0);
    check({tag, " ready1"}, alu_ready, 1);
    if (poke) begin
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        seen |= alu_done;
      end
      check({tag, " no2nd"}, seen, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    int          elat;
    logic        ecb, seen;
    logic [W-1:0] ra, rb;
    int          rop;

    alu_rst = 1'b1; alu_start = 1'b0; alu_op = '0; alu_a = '0; alu_b = '0;
    m_c = 1'b0; m_bf = 1'b0;
    #2;
    check_reset("por");
    tick();
    alu_rst = 1'b0;

    run_op("add",  0, 8'hF0, 8'h20, 0);
    run_op("and",  2, 8'h0F, 8'hF0, 0);
    run_op("sub1", 1, 8'h05, 8'h07, 0);
    run_op("sub2", 1, 8'h07, 8'h07, 0);
    run_op("mul",  8, 8'h10, 8'h10, 1);
    run_op("shl",  6, 8'h81, 8'h00, 0);
    run_op("shr",  7, 8'h01, 8'h00, 0);
    run_op("not",  5, 8'hFF, 8'h00, 0);
    run_op("nop",  12, 8'h00, 8'h5A, 0);
    run_op("add2", 0, 8'h01, 8'h01, 0);

    // Asynchronous reset mid-cycle with non-zero outputs.
    #3 alu_rst = 1'b1;
    #1 check_reset("async");
    m_c = 1'b0; m_bf = 1'b0;
    tick();
    alu_rst = 1'b0;

    // Start held high: re-accepted on the first IDLE cycle after DONE.
    alu_op = 4'd0; alu_a = 8'd1; alu_b = 8'd2; alu_start = 1'b1;
    model(0, 1, 2, er, elat, ecb);
    tick();
    check("hold done_a", alu_done, 1);
    check("hold res_a", alu_result, er);
    alu_a = 8'd3; alu_b = 8'd4;
    tick();
    check("hold idle_ready", alu_ready, 1);
    check("hold idle_done", alu_done, 0);
    model(0, 3, 4, er, elat, ecb);
    tick();
    check("hold done_b", alu_done, 1);
    check("hold res_b", alu_result, er);
    alu_start = 1'b0;
    tick();

    // Abort MUL with reset in its 4th ITER cycle.
    alu_op = 4'd8; alu_a = 8'd3; alu_b = 8'd5; alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    tick(); tick(); tick();
    #2 alu_rst = 1'b1;
    #1 check_reset("abort");
    m_c = 1'b0; m_bf = 1'b0;
    tick();
    alu_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen |= alu_done;
      tick();
    end
    check("abort no_done", seen, 0);
    run_op("mul35", 8, 8'd3, 8'd5, 0);

`ifdef ALU_DIV_EN
    run_op("div",  9, 8'd100, 8'd7, 0);
    run_op("div0", 9, 8'd100, 8'd0, 0);
`endif

    for (int i = 0; i < 50; i++) begin
      rop = int'($urandom_range(0, 15));
      if (i % 5 == 0) rop = 8;
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
